ring_pe_driver: RTL and testbench
=================================

# ring_pe_driver

Processing-element traffic driver that sits directly upstream of one NIC in the 4-node gold ring and drives that NIC's processor-side port (addr, d_in, d_out, nicEn, nicWrEn). It runs a fixed traffic program: it polls output status, builds and writes routed packets to the NIC output buffer, and polls input status to drain and check the NIC input buffer. It replaces the hand-written stimulus loops with a synthesizable, self-checking per-node engine. Four instances, one per node, exercise the whole ring.

## Interface
- NODE_ID, 0: this node's ring index, 0..3.
- NUM_PKTS, 6: packets to send per run, 1..65535.
- EXPECT_RX, 6: packets to receive before finishing, 0..65535.
- TIMEOUT, 1000: cycles from start before a forced abort.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run; ignored unless the block is in IDLE or DONE.
- polarity  in  1  NIC polarity; copied into packet vc bit [0].
- addr  out  [0:1]  NIC register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- d_in  out  [0:63]  write data to NIC.
- d_out  in  [0:63]  NIC read data. Status registers report in bit [63]; the other bits are 0.
- nicEn  out  1  NIC access enable.
- nicWrEn  out  1  NIC write enable; valid only with nicEn.
- sent_count  out  16  packets written this run.
- recv_count  out  16  packets read this run.
- err  out  1  sticky; set on a payload-destination mismatch.
- timeout  out  1  sticky; set when TIMEOUT expires.
- done  out  1  high while in DONE.

## Operation
- Packet format (bit 0 = MSB):
  - [0] vc = polarity
  - [1] dir: 0 cw, 1 ccw
  - [2:7] = 0
  - [8:15] hop count
  - [16:31] source = NODE_ID
  - [32:47] sequence number = sent_count
  - [48:63] destination id
- Destination sequence: round-robin over the three other nodes, starting at (NODE_ID+1) mod 4. The list advances only after a successful write.
- Routing uses d = (dst − NODE_ID) mod 4:
  - d=1: dir 0, hop 1
  - d=2: dir 0, hop 2 (ties go clockwise)
  - d=3: dir 1, hop 1
- FSM states: IDLE, TX_POLL, TX_CHECK, TX_WRITE, RX_POLL, RX_CHECK, RX_READ, RX_DATA, DONE.
- IDLE/DONE + start: clear counts, err, timeout and the cycle counter, then go to TX_POLL.
- TX_POLL: drive addr=11, nicEn=1, nicWrEn=0, then go to TX_CHECK.
- TX_CHECK: nicEn=0. Sample d_out[63].
  - 0 (output buffer empty): go to TX_WRITE.
  - 1: go to RX_POLL. There is no stall on a busy output buffer.
- TX_WRITE: drive addr=10, nicEn=1, nicWrEn=1 and the packet on d_in. Increment sent_count, then go to RX_POLL.
- RX_POLL: drive addr=01, nicEn=1, nicWrEn=0, then go to RX_CHECK.
- RX_CHECK: sample d_out[63]. 1 goes to RX_READ, 0 goes to the scheduler.
- RX_READ: drive addr=00, nicEn=1, then go to RX_DATA.
- RX_DATA: capture d_out and increment recv_count. If d_out[48:63] ≠ NODE_ID, set err. Then go to the scheduler.
- Scheduler, evaluated at the point of exit:
  - If sent_count==NUM_PKTS and recv_count==EXPECT_RX, go to DONE.
  - Otherwise, if sent_count<NUM_PKTS, go to TX_POLL.
  - Otherwise go to RX_POLL.
- The TX phase is skipped once sent_count==NUM_PKTS. The RX phase is skipped once recv_count==EXPECT_RX.
- Timeout: the cycle counter runs in every non-IDLE, non-DONE state. When it reaches TIMEOUT, set timeout and go to DONE. Timeout takes priority over any transition in that cycle.

## Timing
- Reset (asynchronous, active-low) sets all of the following immediately, including mid-access:
  - state = IDLE
  - addr = 00, d_in = 0, nicEn = 0, nicWrEn = 0
  - counts = 0, err = 0, timeout = 0, done = 0
- All outputs are registered.
- nicEn is high for exactly one cycle per access. Every access is followed by at least one cycle with nicEn=0.
- NIC read latency is one cycle. d_out is sampled at the clock edge that ends the cycle after the request.
- Send round trip: status request cycle, then check cycle, then write cycle. The minimum spacing between two successive writes is 3 cycles plus the RX phase: 5 cycles with no RX data, 7 cycles when a packet is read.
- Counters are 16-bit and never wrap within one run, because their limits are parameters.
- done asserts the cycle after the final count update and holds until reset or the next start.

## Test plan
- Reset: hold reset=0 with clk running → all outputs 0, state IDLE. Then release reset and pulse start → nicEn=1 with addr=11 on the next cycle.
- NODE_ID=0, polarity=1, status always empty, EXPECT_RX=0 → writes go to dst 1, 2, 3 with:
  - d_in=64'h8001_0000_0000_0001
  - d_in=64'h8002_0000_0001_0002
  - d_in=64'hC001_0000_0002_0003
  - done asserts after 3 writes when NUM_PKTS=3.
- Output status held at 1 for 10 polls, then 0 → no write during the busy period, exactly one write afterwards, and sent_count increments only then.
- NODE_ID=2, input status 1, d_out data = 64'h…_0002 three times, then 64'h…_0001 → recv_count=4, err=1 set at the fourth read only.
- Assert reset during TX_WRITE → nicEn/nicWrEn drop asynchronously and sent_count=0. A new start restarts from TX_POLL.
- TIMEOUT=50, output and input status held busy/empty → timeout=1 and done=1 at cycle 50, with no further NIC accesses after that.

Source files
------------

// File: rtl/ring_pe_driver.sv
// ring_pe_driver
// Per-node traffic engine that drives one NIC's processor-side port in the
// 4-node ring. It polls output status, writes routed packets into the NIC
// output buffer, and polls input status to drain and check the input buffer.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      one-cycle pulse; honoured only in IDLE or DONE
//   polarity   NIC polarity, copied into packet vc bit [0]
//   addr       NIC register select (00 in buf, 01 in status, 10 out buf, 11 out status)
//   d_in       write data to the NIC
//   d_out      read data from the NIC (status in bit [63])
//   nicEn      NIC access enable, one cycle per access
//   nicWrEn    NIC write enable, meaningful only with nicEn
//   sent_count packets written this run
//   recv_count packets read this run
//   err        sticky payload-destination mismatch flag
//   timeout    sticky flag, set when the run is aborted by the cycle limit
//   done       high while in DONE
module ring_pe_driver #(
  parameter int NODE_ID   = 0,
  parameter int NUM_PKTS  = 6,
  parameter int EXPECT_RX = 6,
  parameter int TIMEOUT   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        polarity,
  output logic [0:1]  addr,
  output logic [0:63] d_in,
  input  logic [0:63] d_out,
  output logic        nicEn,
  output logic        nicWrEn,
  output logic [15:0] sent_count,
  output logic [15:0] recv_count,
  output logic        err,
  output logic        timeout,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, TX_POLL, TX_CHECK, TX_WRITE, RX_POLL, RX_CHECK, RX_READ, RX_DATA, DONE
  } state_t;

  localparam logic [15:0] C_NUM     = 16'(NUM_PKTS);
  localparam logic [15:0] C_EXP     = 16'(EXPECT_RX);
  localparam logic [31:0] C_TO_LAST = 32'(TIMEOUT - 1);
  localparam logic [1:0]  C_NODE    = 2'(NODE_ID);
  localparam logic [15:0] C_NODE16  = 16'(NODE_ID);

  state_t       r_state;
  logic [31:0]  r_cyc;
  logic [1:0]   r_dst_idx;
  logic [0:1]   r_addr;
  logic [0:63]  r_d_in;
  logic         r_nic_en;
  logic         r_nic_wr_en;
  logic [15:0]  r_sent;
  logic [15:0]  r_recv;
  logic         r_err;
  logic         r_timeout;
  logic         r_done;

  state_t       w_state_nxt;
  logic [31:0]  w_cyc_nxt;
  logic [1:0]   w_dst_idx_nxt;
  logic [15:0]  w_sent_nxt;
  logic [15:0]  w_recv_nxt;
  logic         w_err_nxt;
  logic         w_to_nxt;
  logic [0:1]   w_addr_nxt;
  logic [0:63]  w_d_in_nxt;
  logic         w_en_nxt;
  logic         w_wr_nxt;
  logic [1:0]   w_dist;
  logic [1:0]   w_dst;
  logic         w_dir;
  logic [7:0]   w_hop;
  logic [0:63]  w_pkt;
  logic         w_unused_payload;

  // Only the destination field and the status bit of read data matter here.
  assign w_unused_payload = ^d_out[0:47];

  // Ring distance 1..3 to the current destination; distance 2 ties go clockwise.
  assign w_dist = r_dst_idx + 2'd1;
  assign w_dst  = C_NODE + w_dist;
  assign w_dir  = (w_dist == 2'd3);
  assign w_hop  = (w_dist == 2'd2) ? 8'd2 : 8'd1;
  assign w_pkt  = {polarity, w_dir, 6'b000000, w_hop, C_NODE16, r_sent, 14'd0, w_dst};

  // Decide where to go after a TX/RX phase, using counts as they will be after this cycle.
  function automatic state_t f_sched(input logic [15:0] sent, input logic [15:0] recv);
    state_t v_next;
    if (sent == C_NUM && recv == C_EXP) begin
      v_next = DONE;
    end else if (sent < C_NUM) begin
      v_next = TX_POLL;
    end else begin
      v_next = RX_POLL;
    end
    return v_next;
  endfunction

  // Next-state, counter and sticky-flag logic; the cycle limit overrides any transition.
  always_comb begin
    w_state_nxt   = r_state;
    w_cyc_nxt     = r_cyc;
    w_dst_idx_nxt = r_dst_idx;
    w_sent_nxt    = r_sent;
    w_recv_nxt    = r_recv;
    w_err_nxt     = r_err;
    w_to_nxt      = r_timeout;
    if (r_state == IDLE || r_state == DONE) begin
      if (start) begin
        w_state_nxt   = TX_POLL;
        w_cyc_nxt     = 32'd0;
        w_dst_idx_nxt = 2'd0;
        w_sent_nxt    = 16'd0;
        w_recv_nxt    = 16'd0;
        w_err_nxt     = 1'b0;
        w_to_nxt      = 1'b0;
      end else begin
        w_state_nxt = r_state;
      end
    end else if (r_cyc >= C_TO_LAST) begin
      w_to_nxt    = 1'b1;
      w_state_nxt = DONE;
    end else begin
      w_cyc_nxt = r_cyc + 32'd1;
      case (r_state)
        TX_POLL:  w_state_nxt = TX_CHECK;
        TX_CHECK: begin
          if (!d_out[63]) begin
            w_state_nxt = TX_WRITE;
          end else if (r_recv == C_EXP) begin
            w_state_nxt = f_sched(r_sent, r_recv);
          end else begin
            w_state_nxt = RX_POLL;
          end
        end
        TX_WRITE: begin
          w_sent_nxt    = r_sent + 16'd1;
          w_dst_idx_nxt = (r_dst_idx == 2'd2) ? 2'd0 : r_dst_idx + 2'd1;
          if (r_recv == C_EXP) begin
            w_state_nxt = f_sched(r_sent + 16'd1, r_recv);
          end else begin
            w_state_nxt = RX_POLL;
          end
        end
        RX_POLL:  w_state_nxt = RX_CHECK;
        RX_CHECK: begin
          if (d_out[63]) begin
            w_state_nxt = RX_READ;
          end else begin
            w_state_nxt = f_sched(r_sent, r_recv);
          end
        end
        RX_READ:  w_state_nxt = RX_DATA;
        RX_DATA: begin
          w_recv_nxt = r_recv + 16'd1;
          if (d_out[48:63] != C_NODE16) begin
            w_err_nxt = 1'b1;
          end else begin
            w_err_nxt = r_err;
          end
          w_state_nxt = f_sched(r_sent, r_recv + 16'd1);
        end
        default:  w_state_nxt = IDLE;
      endcase
    end
  end

  // NIC drive values for the state being entered, so the port is fully registered.
  always_comb begin
    w_addr_nxt = 2'b00;
    w_d_in_nxt = 64'd0;
    w_en_nxt   = 1'b0;
    w_wr_nxt   = 1'b0;
    case (w_state_nxt)
      TX_POLL: begin
        w_addr_nxt = 2'b11;
        w_en_nxt   = 1'b1;
      end
      TX_WRITE: begin
        w_addr_nxt = 2'b10;
        w_d_in_nxt = w_pkt;
        w_en_nxt   = 1'b1;
        w_wr_nxt   = 1'b1;
      end
      RX_POLL: begin
        w_addr_nxt = 2'b01;
        w_en_nxt   = 1'b1;
      end
      RX_READ: begin
        w_addr_nxt = 2'b00;
        w_en_nxt   = 1'b1;
      end
      default: begin
        w_addr_nxt = 2'b00;
        w_en_nxt   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cyc       <= 32'd0;
      r_dst_idx   <= 2'd0;
      r_addr      <= 2'b00;
      r_d_in      <= 64'd0;
      r_nic_en    <= 1'b0;
      r_nic_wr_en <= 1'b0;
      r_sent      <= 16'd0;
      r_recv      <= 16'd0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cyc       <= w_cyc_nxt;
      r_dst_idx   <= w_dst_idx_nxt;
      r_addr      <= w_addr_nxt;
      r_d_in      <= w_d_in_nxt;
      r_nic_en    <= w_en_nxt;
      r_nic_wr_en <= w_wr_nxt;
      r_sent      <= w_sent_nxt;
      r_recv      <= w_recv_nxt;
      r_err       <= w_err_nxt;
      r_timeout   <= w_to_nxt;
      r_done      <= (w_state_nxt == DONE);
    end
  end

  assign addr       = r_addr;
  assign d_in       = r_d_in;
  assign nicEn      = r_nic_en;
  assign nicWrEn    = r_nic_wr_en;
  assign sent_count = r_sent;
  assign recv_count = r_recv;
  assign err        = r_err;
  assign timeout    = r_timeout;
  assign done       = r_done;

endmodule

// File: tb/tb_ring_pe_driver.sv
// Bench for ring_pe_driver: three instances with small behavioural NIC models.
//   A: node 0, 3 packets, no RX   - reset, packet format, busy output, reset mid-write
//   B: node 2, 1 packet, 4 RX     - receive count and destination-mismatch flag
//   C: node 1, always busy/empty  - cycle-limit abort
module tb_ring_pe_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- instance A ----------------
  logic        a_rst_n = 1'b0, a_start = 1'b0, a_pol = 1'b1;
  logic [0:1]  a_addr;
  logic [0:63] a_d_in;
  logic [0:63] a_d_out = 64'd0;
  logic        a_en, a_wr, a_err, a_to, a_done;
  logic [15:0] a_sent, a_recv;
  int          a_polls = 0;
  int          a_busy_until = 0;
  logic [63:0] a_wr_q[$];
  int          a_wr_polls_q[$];

  ring_pe_driver #(.NODE_ID(0), .NUM_PKTS(3), .EXPECT_RX(0), .TIMEOUT(1000)) u_a (
    .clk(clk), .reset(a_rst_n), .start(a_start), .polarity(a_pol),
    .addr(a_addr), .d_in(a_d_in), .d_out(a_d_out), .nicEn(a_en), .nicWrEn(a_wr),
    .sent_count(a_sent), .recv_count(a_recv), .err(a_err), .timeout(a_to), .done(a_done));

  // NIC model A: output status busy while poll count is below a_busy_until
  always @(posedge clk) begin
    if (a_en && !a_wr) begin
      if (a_addr == 2'b11) begin
        a_d_out <= {63'd0, (a_polls < a_busy_until)};
        a_polls <= a_polls + 1;
      end else begin
        a_d_out <= 64'd0;
      end
    end
    if (a_en && a_wr) begin
      a_wr_q.push_back(a_d_in);
      a_wr_polls_q.push_back(a_polls);
    end
  end

  // ---------------- instances B and C ----------------
  logic        bc_rst_n = 1'b0;
  logic        b_start = 1'b0, c_start = 1'b0, b_pol = 1'b0, c_pol = 1'b0;
  logic [0:1]  b_addr, c_addr;
  logic [0:63] b_d_in, c_d_in;
  logic [0:63] b_d_out = 64'd0, c_d_out = 64'd0;
  logic        b_en, b_wr, b_err, b_to, b_done;
  logic        c_en, c_wr, c_err, c_to, c_done;
  logic [15:0] b_sent, b_recv, c_sent, c_recv;
  int          b_reads = 0;
  int          c_acc = 0;
  logic [63:0] b_wr_q[$];

  ring_pe_driver #(.NODE_ID(2), .NUM_PKTS(1), .EXPECT_RX(4), .TIMEOUT(1000)) u_b (
    .clk(clk), .reset(bc_rst_n), .start(b_start), .polarity(b_pol),
    .addr(b_addr), .d_in(b_d_in), .d_out(b_d_out), .nicEn(b_en), .nicWrEn(b_wr),
    .sent_count(b_sent), .recv_count(b_recv), .err(b_err), .timeout(b_to), .done(b_done));

  ring_pe_driver #(.NODE_ID(1), .NUM_PKTS(2), .EXPECT_RX(1), .TIMEOUT(50)) u_c (
    .clk(clk), .reset(bc_rst_n), .start(c_start), .polarity(c_pol),
    .addr(c_addr), .d_in(c_d_in), .d_out(c_d_out), .nicEn(c_en), .nicWrEn(c_wr),
    .sent_count(c_sent), .recv_count(c_recv), .err(c_err), .timeout(c_to), .done(c_done));

  // NIC model B: output empty, four packets pending (three for node 2, then one for node 1)
  always @(posedge clk) begin
    if (b_en && !b_wr) begin
      case (b_addr)
        2'b11: b_d_out <= 64'd0;
        2'b01: b_d_out <= {63'd0, (b_reads < 4)};
        2'b00: begin
          b_d_out <= (b_reads < 3) ? 64'h1111_2222_3333_0002 : 64'h4444_5555_6666_0001;
          b_reads <= b_reads + 1;
        end
        default: b_d_out <= 64'd0;
      endcase
    end
    if (b_en && b_wr) b_wr_q.push_back(b_d_in);
  end

  // NIC model C: output always busy, input always empty; counts every access
  always @(posedge clk) begin
    if (c_en) c_acc <= c_acc + 1;
    if (c_en && !c_wr) c_d_out <= (c_addr == 2'b11) ? 64'd1 : 64'd0;
  end

  logic [63:0] exp_a [3] = '{64'h8001_0000_0000_0001, 64'h8002_0000_0001_0002,
                             64'hC001_0000_0002_0003};

  initial begin
    int base, p0, k_done, acc_at;
    logic [63:0] pk;

    // reset state with the clock running
    repeat (3) @(negedge clk);
    chk("rst_addr",  64'(a_addr), 64'd0);
    chk("rst_d_in",  a_d_in, 64'd0);
    chk("rst_en_wr", 64'({a_en, a_wr}), 64'd0);
    chk("rst_flags", 64'({a_err, a_to, a_done}), 64'd0);
    chk("rst_counts", 64'({a_sent, a_recv}), 64'd0);
    a_rst_n  = 1'b1;
    bc_rst_n = 1'b1;
    @(negedge clk);

    // first access follows start by one cycle
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("start_en",   64'(a_en), 64'd1);
    chk("start_addr", 64'(a_addr), 64'd3);
    for (int i = 0; i < 100 && !a_done; i++) @(negedge clk);
    chk("a_done", 64'(a_done), 64'd1);
    chk("a_nwr",  64'(a_wr_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      pk = (i < a_wr_q.size()) ? a_wr_q[i] : 64'd0;
      chk($sformatf("a_pkt%0d", i), pk, exp_a[i]);
    end
    chk("a_sent3", 64'(a_sent), 64'd3);

    // output buffer busy for 10 polls
    base = a_wr_q.size();
    p0 = a_polls;
    a_busy_until = a_polls + 10;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 100 && a_polls < p0 + 10; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("busy_sent0", 64'(a_sent), 64'd0);
    chk("busy_nowr",  64'(a_wr_q.size() - base), 64'd0);
    for (int i = 0; i < 100 && a_wr_q.size() <= base; i++) @(negedge clk);
    chk("busy_wr_seen", 64'(a_wr_q.size() - base), 64'd1);
    pk = (a_wr_q.size() > base) ? 64'(a_wr_polls_q[base] - p0) : 64'd0;
    chk("busy_polls", pk, 64'd11);
    pk = (a_wr_q.size() > base) ? a_wr_q[base] : 64'd0;
    chk("busy_pkt", pk, 64'h8001_0000_0000_0001);
    chk("busy_sent1", 64'(a_sent), 64'd1);
    for (int i = 0; i < 100 && !a_done; i++) @(negedge clk);

    // reset during the second write
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 100 && !(a_wr && a_sent == 16'd1); i++) @(negedge clk);
    chk("mid_wr_seen", 64'(a_wr && a_sent == 16'd1), 64'd1);
    a_rst_n = 1'b0;
    #1;
    chk("arst_en_wr", 64'({a_en, a_wr}), 64'd0);
    chk("arst_sent",  64'(a_sent), 64'd0);
    @(negedge clk);
    a_rst_n = 1'b1;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("restart_en_addr", 64'({a_en, a_addr}), 64'd7);

    // receive path on node 2
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 200 && b_recv < 16'd3; i++) @(negedge clk);
    chk("b_err_before4", 64'({b_recv, b_err}), 64'({16'd3, 1'b0}));
    for (int i = 0; i < 200 && !b_done; i++) @(negedge clk);
    chk("b_done", 64'(b_done), 64'd1);
    chk("b_recv4", 64'(b_recv), 64'd4);
    chk("b_err4",  64'(b_err), 64'd1);
    chk("b_sent1", 64'(b_sent), 64'd1);
    pk = (b_wr_q.size() > 0) ? b_wr_q[0] : 64'd0;
    chk("b_pkt", pk, 64'h0001_0002_0000_0003);

    // cycle limit: done after 50 active cycles
    c_start = 1'b1;
    k_done = 0;
    for (int k = 1; k <= 100 && k_done == 0; k++) begin
      @(negedge clk);
      c_start = 1'b0;
      if (c_done) k_done = k;
    end
    chk("c_done_cycle", 64'(k_done), 64'd51);
    chk("c_timeout", 64'(c_to), 64'd1);
    acc_at = c_acc;
    repeat (10) @(negedge clk);
    chk("c_no_access", 64'(c_acc - acc_at), 64'd0);
    chk("c_sent0", 64'(c_sent), 64'd0);
    chk("c_done_hold", 64'(c_done), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
